// File: rtl/uart_mmio_pkg.sv
// Shared register map, status/control bit positions and access decode for uart_mmio.
// Offsets are relative to a 32-byte aligned window base.
package uart_mmio_pkg;

  localparam logic [4:0] OFS_TX_STAT = 5'h00;
  localparam logic [4:0] OFS_RX_STAT = 5'h04;
  localparam logic [4:0] OFS_TX_DATA = 5'h08;
  localparam logic [4:0] OFS_RX_DATA = 5'h0C;
  localparam logic [4:0] OFS_RX_CNT  = 5'h10;
  localparam logic [4:0] OFS_CTRL    = 5'h14;
  localparam logic [4:0] OFS_CYC     = 5'h18;

  localparam int TX_STAT_IDLE_BIT = 0;
  localparam int RX_STAT_NE_BIT   = 0;
  localparam int RX_STAT_OVR_BIT  = 1;
  localparam int CTRL_SEXT_BIT    = 0;

  typedef enum logic [3:0] {
    ACC_NONE,
    ACC_TX_STAT,
    ACC_RX_STAT,
    ACC_TX_DATA,
    ACC_RX_DATA,
    ACC_RX_CNT,
    ACC_CTRL,
    ACC_CYC,
    ACC_RSVD
  } acc_e;

  // In-window offsets with no register decode to ACC_RSVD: they read 0, writes do nothing.
  function automatic acc_e decode_acc(input logic [31:0] addr, input logic [31:0] base);
    acc_e a;
    if (addr[31:5] != base[31:5]) begin
      a = ACC_NONE;
    end else begin
      case (addr[4:0])
        OFS_TX_STAT: a = ACC_TX_STAT;
        OFS_RX_STAT: a = ACC_RX_STAT;
        OFS_TX_DATA: a = ACC_TX_DATA;
        OFS_RX_DATA: a = ACC_RX_DATA;
        OFS_RX_CNT:  a = ACC_RX_CNT;
        OFS_CTRL:    a = ACC_CTRL;
        OFS_CYC:     a = ACC_CYC;
        default:     a = ACC_RSVD;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// CPU data-memory port as seen by the UART register block.
// master = CPU MEM stage, slave = register block.
interface uart_mmio_if;

  logic [31:0] addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rd_valid;

  modport master (
    output addr, mem_rd, mem_wr, wdata,
    input  rdata, rd_valid
  );

  modport slave (
    input  addr, mem_rd, mem_wr, wdata,
    output rdata, rd_valid
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous RX byte FIFO; head is combinational from storage, count/full/empty from the occupancy register.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module uart_rx_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] push_dat_i,
  output logic [DATA_W-1:0] head_o,
  output logic [AW:0]       count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART register block: RX FIFO with sticky overrun, one-deep TX buffer, registered read-back.
// Optional free-running cycle counter at +0x18 when UART_CYCLE_COUNTER_EN is defined.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DATA_W    = 8,
  parameter int          RX_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_mmio_if.slave        bus,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int AW = $clog2(RX_DEPTH);

  acc_e acc_rd, acc_wr;
  assign acc_rd = bus.mem_rd ? decode_acc(bus.addr, BASE_ADDR) : ACC_NONE;
  assign acc_wr = bus.mem_wr ? decode_acc(bus.addr, BASE_ADDR) : ACC_NONE;

  logic [DATA_W-1:0] fifo_head;
  logic [AW:0]       fifo_count;
  logic              fifo_full, fifo_empty;
  logic              pop, push, ovr_set;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts the incoming byte.
  assign pop     = (acc_rd == ACC_RX_DATA) && !fifo_empty;
  assign push    = rx_valid && (!fifo_full || pop);
  assign ovr_set = rx_valid && !push;

  uart_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RX_DEPTH)
  ) u_rx_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .pop_i      (pop),
    .push_dat_i (rx_data),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign rx_ready = !fifo_full;

  logic [31:0]       rdata_q, rdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              ovr_q, ovr_d;
  logic              ctrl_q, ctrl_d;
  logic [31:0]       cyc_val;
  logic [31:0]       rx_ext;
  logic              tx_hs, tx_load;

  assign rx_ext = ctrl_q ? {{(32-DATA_W){fifo_head[DATA_W-1]}}, fifo_head}
                         : {{(32-DATA_W){1'b0}}, fifo_head};

  // tx_load requires an empty buffer and tx_hs a full one, so a write racing the handshake is dropped.
  assign tx_hs   = tx_valid_q && tx_ready;
  assign tx_load = (acc_wr == ACC_TX_DATA) && !tx_valid_q;

  always_comb begin
    rdata_d = '0;
    case (acc_rd)
      ACC_TX_STAT: rdata_d[TX_STAT_IDLE_BIT] = !tx_valid_q;
      ACC_RX_STAT: begin
        rdata_d[RX_STAT_NE_BIT]  = !fifo_empty;
        rdata_d[RX_STAT_OVR_BIT] = ovr_q;
      end
      ACC_RX_DATA: if (!fifo_empty) rdata_d = rx_ext;
      ACC_RX_CNT:  rdata_d = 32'(fifo_count);
      ACC_CTRL:    rdata_d[CTRL_SEXT_BIT] = ctrl_q;
      ACC_CYC:     rdata_d = cyc_val;
      default:     rdata_d = '0;
    endcase
  end

  always_comb begin
    rd_valid_d = (acc_rd != ACC_NONE);
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    ctrl_d     = ctrl_q;
    ovr_d      = ovr_q;
    if (tx_load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = bus.wdata[DATA_W-1:0];
    end else if (tx_hs) begin
      tx_valid_d = 1'b0;
    end
    if (acc_wr == ACC_CTRL) ctrl_d = bus.wdata[CTRL_SEXT_BIT];
    // A fresh overrun beats the clear-on-read of the status register.
    if (ovr_set)                  ovr_d = 1'b1;
    else if (acc_rd == ACC_RX_STAT) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      ovr_q      <= 1'b0;
      ctrl_q     <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      ovr_q      <= ovr_d;
      ctrl_q     <= ctrl_d;
    end
  end

`ifdef UART_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, cyc_d;

  assign cyc_d = (acc_wr == ACC_CYC) ? 32'd0 : cyc_q + 32'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc_q <= '0;
    else          cyc_q <= cyc_d;
  end

  assign cyc_val = cyc_q;
`else
  assign cyc_val = '0;
`endif

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:DATA_W];

  assign bus.rdata    = rdata_q;
  assign bus.rd_valid = rd_valid_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART register block between the CPU data-memory port and the UART transmitter/receiver. It decodes a parametrised address window and holds received bytes in an RX FIFO with a sticky overrun flag. It buffers one TX byte behind a valid/ready handshake and returns registered read data, with zero or sign extension selected at run time. It replaces the combinational read-back encoder and sits beside data memory in the MEM stage read-back mux.

## Interface
- BASE_ADDR, 32'h8000_0000, start of the register window; must be 32-byte aligned.
- DATA_W, 8, UART byte width; 1..31.
- RX_DEPTH, 8, RX FIFO entries; power of two, at least 2.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset. One clock domain: clk.
- addr  in  32  CPU byte address.
- mem_rd  in  1  read strobe, one cycle per access.
- mem_wr  in  1  write strobe, one cycle per access.
- wdata  in  32  write data.
- rdata  out  32  registered read data.
- rd_valid  out  1  rdata valid. Pulses one cycle after an in-window mem_rd.
- tx_data  out  DATA_W  byte to transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts.
- rx_data  in  DATA_W  byte from receiver.
- rx_valid  in  1  rx_data valid for one cycle. The receiver does not stall.
- rx_ready  out  1  advisory: FIFO not full.

## Operation
- Offsets from BASE_ADDR; all other addresses are ignored.
- +0x00 TX status (read-only): bit0 = !tx_valid.
- +0x04 RX status:
  - bit0 = FIFO non-empty; bit1 = overrun.
  - Reading it clears overrun, unless a new overrun occurs in the same cycle; that new overrun wins.
- +0x08 TX data (write-only):
  - When tx_valid=0, the write loads wdata[DATA_W-1:0] and sets tx_valid.
  - When tx_valid=1, the write is dropped.
- +0x0C RX data (read):
  - Non-empty FIFO: pops the head and returns it, extended per ctrl bit0.
  - Empty FIFO: returns 0 and does not pop.
- +0x10 RX count (read-only): number of occupied entries, 0..RX_DEPTH.
- +0x14 control (read/write): bit0 sign-extend RX data (0 = zero-extend). Other bits read 0.
- +0x18 cycle counter: present only with the macro in Configuration; reads 0 without it.
- TX handshake:
  - tx_valid and tx_data hold steady until a cycle with tx_valid && tx_ready, then tx_valid clears.
  - A TX write in the same cycle as that handshake is dropped, because status showed the buffer busy.
- RX push:
  - The byte is pushed when rx_valid and (count < RX_DEPTH or a pop happens in the same cycle).
  - Otherwise the byte is dropped and overrun is set.
- Simultaneous push and pop: both are performed; count is unchanged; FIFO order is preserved.
- Empty FIFO with push and RX-data read in the same cycle: the read returns 0 and the new byte remains.
- mem_rd and mem_wr in the same cycle: both are serviced independently.
- Pointers are log2(RX_DEPTH) bits wide and wrap modulo RX_DEPTH; count is log2(RX_DEPTH)+1 bits.

## Timing
- Reset values: rdata=0, rd_valid=0, tx_valid=0, tx_data=0, FIFO empty, overrun=0, ctrl=0, cycle counter=0. rx_ready=1 after reset.
- Read latency is one cycle. rdata is 0 whenever rd_valid=0.
- Register-side effects (pop, clear, TX load) take effect at the clk edge that samples the strobe.
- rx_ready is combinational from count: !(count==RX_DEPTH).
- Asserting reset_n low mid-transfer discards FIFO contents and any pending TX byte immediately.

## Configuration
- UART_CYCLE_COUNTER_EN defined:
  - 32-bit free-running counter, wraps at 2^32-1 to 0.
  - Read at +0x18.
  - Any write to +0x18 clears it: it reads 0 the cycle after the write, then increments.
- Undefined: no counter logic; +0x18 reads 0 and writes are ignored.

## Structure
- Package uart_mmio_pkg: register offsets, status/control bit indices, access-decode enum.
- Sub-module uart_rx_fifo: parametrised DATA_W/RX_DEPTH synchronous FIFO with push, pop, count, full, empty.

## Test plan
- After reset: read +0x00 gives 1; +0x04 gives 0; +0x10 gives 0; rx_ready=1.
- RX byte 0x85 with ctrl=0: read +0x0C gives 0x0000_0085. With ctrl=1: gives 0xFFFF_FF85. Count returns to 0.
- Push 9 bytes into RX_DEPTH=8 with no reads:
  - rx_ready=0 after the 8th push.
  - +0x04 reads 0x3; a second read gives 0x1.
  - The 8 pops return bytes 1..8 in order.
- Full FIFO, rx_valid and RX-data read in the same cycle: no overrun; count stays 8; wrap order is correct.
- TX: write 0x41 with tx_ready=0 for 3 cycles; tx_valid holds. A second write 0x42 is dropped. tx_ready=1 completes the transfer; +0x00 reads 1.
- With UART_CYCLE_COUNTER_EN: write +0x18; reading it 5 cycles later gives 4.
